// File: rtl/bp_me_stream_mem_responder.sv
// Memory-side endpoint for the BedRock stream mem_fwd/mem_rev interface: services reads and
// writes from an internal word array and returns mem_rev beats after a fixed read latency.
module bp_me_stream_mem_responder #(
    parameter int paddr_width_p   = 40,
    parameter int l2_data_width_p = 64,
    parameter int mem_els_p       = 1024,
    parameter int read_latency_p  = 4,
    localparam int mem_fwd_header_width_lp = 4 + 4 + paddr_width_p + 3 + 16,
    localparam int mem_rev_header_width_lp = mem_fwd_header_width_lp
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_i,
    input  logic [l2_data_width_p-1:0]         mem_fwd_data_i,
    input  logic                               mem_fwd_v_i,
    output logic                               mem_fwd_ready_and_o,
    output logic [mem_rev_header_width_lp-1:0] mem_rev_header_o,
    output logic [l2_data_width_p-1:0]         mem_rev_data_o,
    output logic                               mem_rev_v_o,
    input  logic                               mem_rev_ready_and_i
);

    localparam int d_lp          = l2_data_width_p;
    localparam int lg_d_lp       = $clog2(d_lp);
    localparam int byte_w_lp     = d_lp / 8;
    localparam int lg_bytes_lp   = $clog2(byte_w_lp);
    localparam int lg_els_lp     = $clog2(mem_els_p);
    localparam int max_beats_lp  = (1024 / d_lp > 1) ? 1024 / d_lp : 1;
    localparam int beat_w_lp     = $clog2(max_beats_lp) + 1;
    localparam int lat_w_lp      = $clog2(read_latency_p + 1);

    // Simplified BedRock header, MSB first: msg_type, subop, addr, size, payload.
    typedef struct packed {
        logic [3:0]               msg_type;
        logic [3:0]               subop;
        logic [paddr_width_p-1:0] addr;
        logic [2:0]               size;
        logic [15:0]              payload;
    } hdr_s;

    localparam logic [3:0] mt_rd_lp    = 4'd0;
    localparam logic [3:0] mt_wr_lp    = 4'd1;
    localparam logic [3:0] mt_uc_rd_lp = 4'd2;
    localparam logic [3:0] mt_uc_wr_lp = 4'd3;

    typedef enum logic [2:0] {
        e_clear, e_ready, e_wr_beats, e_wr_ack, e_rd_wait, e_rd_beats
    } state_e;

    state_e                 state_q;
    logic [lg_els_lp-1:0]   clr_q;
    hdr_s                   hdr_q;
    logic [beat_w_lp-1:0]   k_q;
    logic [lat_w_lp-1:0]    cnt_q;
    logic [d_lp-1:0]        mem_q [mem_els_p];

    function automatic logic [beat_w_lp-1:0] beats_of(input logic [2:0] size);
        int bits;
        bits = 8 << size;
        return (bits <= d_lp) ? beat_w_lp'(1) : beat_w_lp'(bits / d_lp);
    endfunction

    // Critical-word-first: beat k wraps inside the size-aligned region of the address.
    function automatic logic [lg_els_lp-1:0] word_idx(input logic [paddr_width_p-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [beat_w_lp-1:0] k);
        logic [paddr_width_p-1:0] wa;
        logic [paddr_width_p-1:0] m;
        wa = addr >> lg_bytes_lp;
        m  = paddr_width_p'(beats_of(size)) - paddr_width_p'(1);
        wa = (wa & ~m) | ((wa + paddr_width_p'(k)) & m);
        return wa[lg_els_lp-1:0];
    endfunction

    function automatic logic [lg_bytes_lp-1:0] field_mask(input logic [2:0] size);
        if (size >= 3'(lg_bytes_lp)) return '1;
        return lg_bytes_lp'((32'd1 << size) - 32'd1);
    endfunction

    function automatic logic [d_lp-1:0] replicate(input logic [d_lp-1:0] data, input logic [2:0] size);
        logic [d_lp-1:0]    r;
        logic [lg_d_lp-1:0] fm;
        int                 fbits;
        fbits = 8 << size;
        if (fbits > d_lp) fbits = d_lp;
        fm = lg_d_lp'(fbits - 1);
        for (int i = 0; i < d_lp; i++) r[i] = data[lg_d_lp'(i) & fm];
        return r;
    endfunction

    function automatic logic [d_lp-1:0] merge(input logic [d_lp-1:0] old, input logic [d_lp-1:0] data,
                                              input logic [lg_bytes_lp-1:0] boff, input logic [2:0] size);
        logic [d_lp-1:0]        rep;
        logic [d_lp-1:0]        res;
        logic [lg_bytes_lp-1:0] m;
        rep = replicate(data, size);
        res = old;
        m   = field_mask(size);
        for (int j = 0; j < byte_w_lp; j++)
            if ((lg_bytes_lp'(j) & ~m) == (boff & ~m)) res[j*8 +: 8] = rep[j*8 +: 8];
        return res;
    endfunction

    function automatic logic is_rd(input logic [3:0] mt);
        return (mt == mt_rd_lp) || (mt == mt_uc_rd_lp);
    endfunction

    function automatic logic is_wr(input logic [3:0] mt);
        return (mt == mt_wr_lp) || (mt == mt_uc_wr_lp);
    endfunction

    hdr_s                   fwd_hdr;
    logic [lg_els_lp-1:0]   fwd_idx;
    logic [lg_els_lp-1:0]   cur_idx;
    logic [beat_w_lp-1:0]   last_beat;
    logic [lg_bytes_lp-1:0] rd_base;
    logic [d_lp-1:0]        rd_word;
    logic [d_lp-1:0]        rd_data;

    assign fwd_hdr   = mem_fwd_header_i;
    assign fwd_idx   = word_idx(fwd_hdr.addr, fwd_hdr.size, '0);
    assign cur_idx   = word_idx(hdr_q.addr, hdr_q.size, k_q);
    assign last_beat = beats_of(hdr_q.size) - beat_w_lp'(1);

    // Narrow reads shift the addressed field down, then replicate it across the beat.
    always_comb begin
        rd_base = hdr_q.addr[lg_bytes_lp-1:0] & ~field_mask(hdr_q.size);
        rd_word = mem_q[cur_idx];
        rd_data = replicate(rd_word >> {rd_base, 3'b000}, hdr_q.size);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_clear;
            clr_q   <= '0;
            hdr_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                e_clear: begin
                    mem_q[clr_q] <= '0;
                    clr_q        <= clr_q + lg_els_lp'(1);
                    if (clr_q == lg_els_lp'(mem_els_p - 1)) state_q <= e_ready;
                end
                e_ready: if (mem_fwd_v_i) begin
                    hdr_q <= fwd_hdr;
                    if (is_rd(fwd_hdr.msg_type)) begin
                        cnt_q   <= lat_w_lp'(read_latency_p);
                        k_q     <= '0;
                        state_q <= e_rd_wait;
                    end else begin
                        // Unknown message types follow the write flow but leave the array alone.
                        if (is_wr(fwd_hdr.msg_type))
                            mem_q[fwd_idx] <= merge(mem_q[fwd_idx], mem_fwd_data_i,
                                                    fwd_hdr.addr[lg_bytes_lp-1:0], fwd_hdr.size);
                        k_q     <= beat_w_lp'(1);
                        state_q <= (beats_of(fwd_hdr.size) == beat_w_lp'(1)) ? e_wr_ack : e_wr_beats;
                    end
                end
                e_wr_beats: if (mem_fwd_v_i) begin
                    if (is_wr(hdr_q.msg_type))
                        mem_q[cur_idx] <= merge(mem_q[cur_idx], mem_fwd_data_i,
                                                hdr_q.addr[lg_bytes_lp-1:0], hdr_q.size);
                    k_q <= k_q + beat_w_lp'(1);
                    if (k_q == last_beat) state_q <= e_wr_ack;
                end
                e_wr_ack: if (mem_rev_ready_and_i) state_q <= e_ready;
                e_rd_wait: begin
                    cnt_q <= cnt_q - lat_w_lp'(1);
                    if (cnt_q == lat_w_lp'(1)) state_q <= e_rd_beats;
                end
                e_rd_beats: if (mem_rev_ready_and_i) begin
                    k_q <= k_q + beat_w_lp'(1);
                    if (k_q == last_beat) state_q <= e_ready;
                end
                default: state_q <= e_clear;
            endcase
        end
    end

    // Valid/ready: a beat transfers on a rising clk_i edge where both valid and ready are high;
    // mem_rev outputs hold unchanged while valid is high and ready is low.
    assign mem_fwd_ready_and_o = (state_q == e_ready) || (state_q == e_wr_beats);
    assign mem_rev_v_o         = (state_q == e_wr_ack) || (state_q == e_rd_beats);
    assign mem_rev_header_o    = hdr_q;
    assign mem_rev_data_o      = (state_q == e_rd_beats) ? rd_data : '0;

endmodule
